sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 gradient core: streams raster pixels through two line
// buffers into a sliding window, then registers the core result behind a ready/valid output.
module sobel_frame_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic [7:0] data_0_0_o,
  output logic [7:0] data_0_1_o,
  output logic [7:0] data_0_2_o,
  output logic [7:0] data_1_0_o,
  output logic [7:0] data_1_1_o,
  output logic [7:0] data_1_2_o,
  output logic [7:0] data_2_0_o,
  output logic [7:0] data_2_1_o,
  output logic [7:0] data_2_2_o,
  output logic       core_en_o,
  input  logic [7:0] pixel_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic [7:0] lb0_q [IMG_W];
  logic [7:0] lb1_q [IMG_W];

  logic [2:0][2:0][7:0] win_q, win_d;
  logic core_en_q, core_en_d;
  logic core_last_q, core_last_d;

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;

  logic advance;
  logic accept;
  logic last_pix;

  assign advance  = !out_valid_q || out_ready_i;
  assign accept   = in_valid_i && in_ready_o;
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  assign in_ready_o = (state_q == RUN) && advance;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = DRAIN;
      DRAIN:   if (!core_en_q && !out_valid_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == IDLE && start_i) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Columns left over from the previous row are never enabled: col>=2 gates core_en.
  always_comb begin
    win_d       = win_q;
    core_en_d   = core_en_q;
    core_last_d = core_last_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_q[col_q];
      win_d[1][2] = lb0_q[col_q];
      win_d[2][2] = in_data_i;
      core_en_d   = (row_q >= RW'(2)) && (col_q >= CW'(2));
      core_last_d = last_pix;
    end else if (advance) begin
      core_en_d   = 1'b0;
      core_last_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (advance) begin
      out_valid_d = core_en_q;
      out_data_d  = pixel_i;
      out_last_d  = core_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      core_en_q   <= 1'b0;
      core_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      core_en_q   <= core_en_d;
      core_last_q <= core_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffers carry no reset; every entry is rewritten before a window can use it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_data_i;
    end
  end

  assign data_0_0_o  = win_q[0][0];
  assign data_0_1_o  = win_q[0][1];
  assign data_0_2_o  = win_q[0][2];
  assign data_1_0_o  = win_q[1][0];
  assign data_1_1_o  = win_q[1][1];
  assign data_1_2_o  = win_q[1][2];
  assign data_2_0_o  = win_q[2][0];
  assign data_2_1_o  = win_q[2][1];
  assign data_2_2_o  = win_q[2][2];
  assign core_en_o   = core_en_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: a stand-in gradient core feeds pixel_i, and every frame's
// result stream is compared against a direct 3x3 convolution of the stimulus image.
module tb_sobel_frame_ctrl;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int NPIX   = W * H;
  localparam int BUDGET = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic [7:0] data_0_0_o, data_0_1_o, data_0_2_o;
  logic [7:0] data_1_0_o, data_1_1_o, data_1_2_o;
  logic [7:0] data_2_0_o, data_2_1_o, data_2_2_o;
  logic       core_en_o;
  logic [7:0] pixel_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic       out_last_o;
  logic       busy_o;
  logic       done_o;

  int total = 0;
  int bad   = 0;
  int coreMode = 0;
  int cycCnt = 0;
  int doneCnt = 0;
  int firstOutCyc = -1;
  int acceptCyc[$];
  logic [8:0] resQ[$];
  logic [7:0] img [H][W];
  logic [2:0][2:0][7:0] dutWin;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .data_0_0_o(data_0_0_o), .data_0_1_o(data_0_1_o), .data_0_2_o(data_0_2_o),
    .data_1_0_o(data_1_0_o), .data_1_1_o(data_1_1_o), .data_1_2_o(data_1_2_o),
    .data_2_0_o(data_2_0_o), .data_2_1_o(data_2_1_o), .data_2_2_o(data_2_2_o),
    .core_en_o(core_en_o), .pixel_i(pixel_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Mode 0 is a saturating |Gx|+|Gy| Sobel; mode 1 is a position-weighted sum that exposes window misordering.
  function automatic logic [7:0] coreFn(input int mode, input logic [2:0][2:0][7:0] w);
    int gx;
    int gy;
    int s;
    s = 0;
    if (mode == 0) begin
      gx = int'(w[0][2]) + 2 * int'(w[1][2]) + int'(w[2][2])
         - int'(w[0][0]) - 2 * int'(w[1][0]) - int'(w[2][0]);
      gy = int'(w[2][0]) + 2 * int'(w[2][1]) + int'(w[2][2])
         - int'(w[0][0]) - 2 * int'(w[0][1]) - int'(w[0][2]);
      s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (s > 255) s = 255;
    end else begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          s = s + (2 * (3 * r + c) + 1) * int'(w[r][c]);
    end
    return s[7:0];
  endfunction

  always_comb begin
    dutWin[0][0] = data_0_0_o; dutWin[0][1] = data_0_1_o; dutWin[0][2] = data_0_2_o;
    dutWin[1][0] = data_1_0_o; dutWin[1][1] = data_1_1_o; dutWin[1][2] = data_1_2_o;
    dutWin[2][0] = data_2_0_o; dutWin[2][1] = data_2_1_o; dutWin[2][2] = data_2_2_o;
    pixel_i = coreFn(coreMode, dutWin);
  end

  always @(posedge clk) cycCnt <= cycCnt + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_o && out_ready_i) resQ.push_back({out_last_o, out_data_o});
      if (out_valid_o && firstOutCyc < 0) firstOutCyc = cycCnt;
      if (in_valid_i && in_ready_o) acceptCyc.push_back(cycCnt);
      if (done_o) doneCnt++;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic fillImage(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0:       img[r][c] = 8'd100;
          1:       img[r][c] = (c < 4) ? 8'h00 : 8'hFF;
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // Streams img as one frame; abortAfter >= 0 stops once that many pixels are accepted.
  task automatic applyStimulus(input int validMode, input int readyMode, input bit pokeStart,
                               input int abortAfter);
    int idx;
    int budget;
    bit fire;
    bit poked;
    bit stallDone;
    int stallLeft;
    logic [8:0] held;
    idx = 0; budget = 0; poked = 0; stallDone = 0; stallLeft = 0; held = '0;
    resQ.delete(); acceptCyc.delete(); firstOutCyc = -1; doneCnt = 0;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (!(idx >= NPIX && doneCnt > 0) && budget < BUDGET) begin
      if (abortAfter >= 0 && idx == abortAfter) break;
      in_valid_i = (idx < NPIX) && (validMode == 0 || $urandom_range(0, 3) != 0);
      in_data_i  = (idx < NPIX) ? img[idx / W][idx % W] : 8'h00;
      start_i    = pokeStart && !poked && idx == 20;
      if (start_i) poked = 1'b1;
      if (readyMode == 2 && !stallDone && idx >= 30 && out_valid_o) begin
        stallDone = 1'b1;
        stallLeft = 5;
        held = {out_last_o, out_data_o};
      end
      if (stallLeft > 0)        out_ready_i = 1'b0;
      else if (readyMode == 1)  out_ready_i = ($urandom_range(0, 2) != 0);
      else                      out_ready_i = 1'b1;
      @(negedge clk);
      fire = in_valid_i && in_ready_o;
      if (stallLeft > 0) begin
        checkOutput("stall_in_ready", int'(in_ready_o), 0);
        checkOutput("stall_valid", int'(out_valid_o), 1);
        checkOutput("stall_data", int'({out_last_o, out_data_o}), int'(held));
        stallLeft--;
      end
      @(posedge clk); #1;
      if (fire) idx++;
      budget++;
    end
    start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    if (abortAfter < 0) checkOutput("frame_finished", int'(budget < BUDGET), 1);
    if (readyMode == 2) checkOutput("stall_seen", int'(stallDone), 1);
  endtask

  task automatic checkFrame(input string tag);
    logic [8:0] expQ[$];
    logic [2:0][2:0][7:0] w;
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[i][j] = img[r - 1 + i][c - 1 + j];
        expQ.push_back({(r == H - 2 && c == W - 2), coreFn(coreMode, w)});
      end
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_count"}, resQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      checkOutput($sformatf("%s_res%0d", tag, i),
                  (i < resQ.size()) ? int'(resQ[i]) : 32'hDEAD, int'(expQ[i]));
    checkOutput({tag, "_done_once"}, doneCnt, 1);
    checkOutput({tag, "_idle"}, int'(busy_o), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready_o), 0);
    checkOutput({tag, "_core_en"}, int'(core_en_o), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid_o), 0);
    checkOutput({tag, "_out_last"}, int'(out_last_o), 0);
    checkOutput({tag, "_out_data"}, int'(out_data_o), 0);
    checkOutput({tag, "_busy"}, int'(busy_o), 0);
    checkOutput({tag, "_done"}, int'(done_o), 0);
    checkOutput({tag, "_window"}, int'(dutWin != '0), 0);
  endtask

  initial begin
    logic [7:0] edgeRow [6];
    int span;
    int firstLat;
    edgeRow[0] = 8'h00; edgeRow[1] = 8'h00; edgeRow[2] = 8'hFF;
    edgeRow[3] = 8'hFF; edgeRow[4] = 8'h00; edgeRow[5] = 8'h00;

    rst_n = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
    #3;
    checkResetState("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    coreMode = 0;
    fillImage(0);
    applyStimulus(0, 0, 1'b0, -1);
    span     = (acceptCyc.size() >= NPIX) ? acceptCyc[NPIX - 1] - acceptCyc[0] : -1;
    firstLat = (acceptCyc.size() >= 19) ? firstOutCyc - acceptCyc[18] : -1;
    checkOutput("accept_count", acceptCyc.size(), NPIX);
    checkOutput("accept_span", span, NPIX - 1);
    checkOutput("first_out_latency", firstLat, 2);
    checkFrame("flat");

    fillImage(1);
    applyStimulus(0, 0, 1'b0, -1);
    checkFrame("edge");
    for (int i = 0; i < resQ.size(); i++)
      checkOutput($sformatf("edge_pattern%0d", i), int'(resQ[i][7:0]), int'(edgeRow[i % 6]));

    coreMode = 1;
    fillImage(2);
    applyStimulus(0, 2, 1'b0, -1);
    checkFrame("stalled");
    applyStimulus(0, 0, 1'b0, -1);
    checkFrame("unstalled");

    fillImage(2);
    applyStimulus(1, 1, 1'b1, -1);
    checkFrame("rand_poke");

    fillImage(2);
    applyStimulus(0, 0, 1'b0, 25);
    rst_n = 1'b0;
    #1;
    checkResetState("abort");
    checkOutput("abort_no_done", doneCnt, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    fillImage(2);
    applyStimulus(1, 1, 1'b0, -1);
    checkFrame("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
